// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one memory port between the instruction-fetch bus
// and the data bus. Arbitration is round-robin. A watchdog force-completes
// with an error any transaction that memory never acknowledges.
module rv32i_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ibus_req,
  input  logic [31:0] i_ibus_addr,
  output logic        o_ibus_ack,
  output logic        o_ibus_err,
  output logic [31:0] o_ibus_rdata,
  input  logic        i_dbus_req,
  input  logic        i_dbus_we,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_wstrb,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  output logic [31:0] o_dbus_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            lastD_q, lastD_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            memReq_q, memReq_d;
  logic            memWe_q, memWe_d;
  logic [31:0]     memAddr_q, memAddr_d;
  logic [31:0]     memWdata_q, memWdata_d;
  logic [3:0]      memWstrb_q, memWstrb_d;
  logic            ibusAck_q, ibusAck_d;
  logic            ibusErr_q, ibusErr_d;
  logic [31:0]     ibusRdata_q, ibusRdata_d;
  logic            dbusAck_q, dbusAck_d;
  logic            dbusErr_q, dbusErr_d;
  logic [31:0]     dbusRdata_q, dbusRdata_d;
  logic            done;
  logic            timedOut;

  // Next-state logic: arbitrate in IDLE, wait for ack or watchdog in a grant
  // state, pulse the completion for one cycle in RESP.
  always_comb begin
    state_d     = state_q;
    lastD_d     = lastD_q;
    cnt_d       = cnt_q;
    memReq_d    = memReq_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    memWstrb_d  = memWstrb_q;
    ibusAck_d   = 1'b0;
    ibusErr_d   = 1'b0;
    ibusRdata_d = ibusRdata_q;
    dbusAck_d   = 1'b0;
    dbusErr_d   = 1'b0;
    dbusRdata_d = dbusRdata_q;
    done        = i_mem_ack || (cnt_q == CntLast);
    timedOut    = !i_mem_ack;

    case (state_q)
      IDLE: begin
        if (i_ibus_req && (!i_dbus_req || lastD_q)) begin
          state_d    = GRANT_I;
          memReq_d   = 1'b1;
          memWe_d    = 1'b0;
          memAddr_d  = i_ibus_addr;
          memWstrb_d = 4'b0;
          cnt_d      = '0;
        end else if (i_dbus_req) begin
          state_d    = GRANT_D;
          memReq_d   = 1'b1;
          memWe_d    = i_dbus_we;
          memAddr_d  = i_dbus_addr;
          memWdata_d = i_dbus_wdata;
          memWstrb_d = i_dbus_wstrb;
          cnt_d      = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (done) begin
          state_d  = RESP;
          memReq_d = 1'b0;
          lastD_d  = (state_q == GRANT_D);
          if (state_q == GRANT_I) begin
            ibusAck_d   = 1'b1;
            ibusErr_d   = timedOut;
            ibusRdata_d = timedOut ? 32'b0 : i_mem_rdata;
          end else begin
            dbusAck_d   = 1'b1;
            dbusErr_d   = timedOut;
            dbusRdata_d = (timedOut || memWe_q) ? 32'b0 : i_mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      lastD_q     <= 1'b1;
      cnt_q       <= '0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= 32'b0;
      memWdata_q  <= 32'b0;
      memWstrb_q  <= 4'b0;
      ibusAck_q   <= 1'b0;
      ibusErr_q   <= 1'b0;
      ibusRdata_q <= 32'b0;
      dbusAck_q   <= 1'b0;
      dbusErr_q   <= 1'b0;
      dbusRdata_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      lastD_q     <= lastD_d;
      cnt_q       <= cnt_d;
      memReq_q    <= memReq_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      memWstrb_q  <= memWstrb_d;
      ibusAck_q   <= ibusAck_d;
      ibusErr_q   <= ibusErr_d;
      ibusRdata_q <= ibusRdata_d;
      dbusAck_q   <= dbusAck_d;
      dbusErr_q   <= dbusErr_d;
      dbusRdata_q <= dbusRdata_d;
    end
  end

  assign o_mem_req    = memReq_q;
  assign o_mem_we     = memWe_q;
  assign o_mem_addr   = memAddr_q;
  assign o_mem_wdata  = memWdata_q;
  assign o_mem_wstrb  = memWstrb_q;
  assign o_ibus_ack   = ibusAck_q;
  assign o_ibus_err   = ibusErr_q;
  assign o_ibus_rdata = ibusRdata_q;
  assign o_dbus_ack   = dbusAck_q;
  assign o_dbus_err   = dbusErr_q;
  assign o_dbus_rdata = dbusRdata_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed testbench for rv32i_mem_arbiter with a short watchdog (TIMEOUT = 4).
module tb_rv32i_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ibusReq;
  logic [31:0] ibusAddr;
  logic        ibusAck;
  logic        ibusErr;
  logic [31:0] ibusRdata;
  logic        dbusReq;
  logic        dbusWe;
  logic [31:0] dbusAddr;
  logic [31:0] dbusWdata;
  logic [3:0]  dbusWstrb;
  logic        dbusAck;
  logic        dbusErr;
  logic [31:0] dbusRdata;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic        memAck;
  logic [31:0] memRdata;

  int checks = 0;
  int errors = 0;
  int reqCycles;
  logic expI;

  rv32i_mem_arbiter #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ibus_req   (ibusReq),
    .i_ibus_addr  (ibusAddr),
    .o_ibus_ack   (ibusAck),
    .o_ibus_err   (ibusErr),
    .o_ibus_rdata (ibusRdata),
    .i_dbus_req   (dbusReq),
    .i_dbus_we    (dbusWe),
    .i_dbus_addr  (dbusAddr),
    .i_dbus_wdata (dbusWdata),
    .i_dbus_wstrb (dbusWstrb),
    .o_dbus_ack   (dbusAck),
    .o_dbus_err   (dbusErr),
    .o_dbus_rdata (dbusRdata),
    .o_mem_req    (memReq),
    .o_mem_we     (memWe),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_mem_wstrb  (memWstrb),
    .i_mem_ack    (memAck),
    .i_mem_rdata  (memRdata)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, where outputs are sampled and inputs driven.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata,
                               input logic [3:0] dWstrb);
    ibusReq   = iReq;
    ibusAddr  = iAddr;
    dbusReq   = dReq;
    dbusWe    = dWe;
    dbusAddr  = dAddr;
    dbusWdata = dWdata;
    dbusWstrb = dWstrb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem_req"},    32'(memReq),    32'h0);
    checkOutput({tag, " mem_we"},     32'(memWe),     32'h0);
    checkOutput({tag, " mem_addr"},   memAddr,        32'h0);
    checkOutput({tag, " mem_wdata"},  memWdata,       32'h0);
    checkOutput({tag, " mem_wstrb"},  32'(memWstrb),  32'h0);
    checkOutput({tag, " ibus_ack"},   32'(ibusAck),   32'h0);
    checkOutput({tag, " ibus_err"},   32'(ibusErr),   32'h0);
    checkOutput({tag, " ibus_rdata"}, ibusRdata,      32'h0);
    checkOutput({tag, " dbus_ack"},   32'(dbusAck),   32'h0);
    checkOutput({tag, " dbus_err"},   32'(dbusErr),   32'h0);
    checkOutput({tag, " dbus_rdata"}, dbusRdata,      32'h0);
  endtask

  // Directed sequence covering fetch, contention, round-robin, timeout and reset.
  initial begin
    rst = 1'b1;
    memAck = 1'b0;
    memRdata = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;

    // Single fetch.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("fetch mem_req", 32'(memReq), 32'h1);
    checkOutput("fetch mem_addr", memAddr, 32'h40);
    checkOutput("fetch mem_we", 32'(memWe), 32'h0);
    memAck = 1'b1;
    memRdata = 32'h13;
    tick();
    checkOutput("fetch ibus_ack", 32'(ibusAck), 32'h1);
    checkOutput("fetch ibus_rdata", ibusRdata, 32'h13);
    checkOutput("fetch ibus_err", 32'(ibusErr), 32'h0);
    checkOutput("fetch dbus_ack", 32'(dbusAck), 32'h0);
    checkOutput("fetch mem_req low", 32'(memReq), 32'h0);
    memAck = 1'b0;
    ibusReq = 1'b0;
    tick();
    checkOutput("fetch ack pulse", 32'(ibusAck), 32'h0);
    checkOutput("fetch addr held", memAddr, 32'h40);
    checkOutput("fetch rdata held", ibusRdata, 32'h13);

    // Contention straight after reset: ibus first, then the dbus store.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    tick();
    checkOutput("cont first addr", memAddr, 32'h80);
    checkOutput("cont first we", 32'(memWe), 32'h0);
    checkOutput("cont first wstrb", 32'(memWstrb), 32'h0);
    memAck = 1'b1;
    memRdata = 32'h1111_1111;
    tick();
    checkOutput("cont ibus_ack", 32'(ibusAck), 32'h1);
    checkOutput("cont ibus_rdata", ibusRdata, 32'h1111_1111);
    checkOutput("cont dbus_ack early", 32'(dbusAck), 32'h0);
    memAck = 1'b0;
    ibusReq = 1'b0;
    tick();
    checkOutput("cont idle mem_req", 32'(memReq), 32'h0);
    tick();
    checkOutput("cont store mem_req", 32'(memReq), 32'h1);
    checkOutput("cont store we", 32'(memWe), 32'h1);
    checkOutput("cont store addr", memAddr, 32'h100);
    checkOutput("cont store wdata", memWdata, 32'hDEADBEEF);
    checkOutput("cont store wstrb", 32'(memWstrb), 32'hF);
    memAck = 1'b1;
    memRdata = 32'h5555_5555;
    tick();
    checkOutput("cont dbus_ack", 32'(dbusAck), 32'h1);
    checkOutput("cont dbus_err", 32'(dbusErr), 32'h0);
    checkOutput("cont store rdata", dbusRdata, 32'h0);
    memAck = 1'b0;
    dbusReq = 1'b0;
    tick();

    // Round-robin with both requesters held high: D was last, so I, D, I, D.
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      expI = (k % 2 == 0);
      tick();
      checkOutput($sformatf("rr%0d addr", k), memAddr, expI ? 32'h200 : 32'h300);
      memAck = 1'b1;
      memRdata = 32'hA0 + 32'(k);
      tick();
      checkOutput($sformatf("rr%0d ibus_ack", k), 32'(ibusAck), 32'(expI));
      checkOutput($sformatf("rr%0d dbus_ack", k), 32'(dbusAck), 32'(!expI));
      checkOutput($sformatf("rr%0d rdata", k), expI ? ibusRdata : dbusRdata, 32'hA0 + 32'(k));
      memAck = 1'b0;
      tick();
      checkOutput($sformatf("rr%0d acks low", k), 32'({ibusAck, dbusAck}), 32'h0);
      if (k == 3) begin
        ibusReq = 1'b0;
        dbusReq = 1'b0;
      end
    end

    // Watchdog: dbus load that memory never acknowledges.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    reqCycles = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (memReq) reqCycles++;
      if (dbusAck) break;
    end
    checkOutput("to req cycles", 32'(reqCycles), 32'd4);
    checkOutput("to dbus_ack", 32'(dbusAck), 32'h1);
    checkOutput("to dbus_err", 32'(dbusErr), 32'h1);
    checkOutput("to dbus_rdata", dbusRdata, 32'h0);
    dbusReq = 1'b0;
    tick();
    checkOutput("to err pulse", 32'(dbusErr), 32'h0);

    // Next request after a timeout is served normally.
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    memAck = 1'b1;
    memRdata = 32'h77;
    tick();
    checkOutput("post-to ibus_ack", 32'(ibusAck), 32'h1);
    checkOutput("post-to ibus_err", 32'(ibusErr), 32'h0);
    checkOutput("post-to ibus_rdata", ibusRdata, 32'h77);
    memAck = 1'b0;
    ibusReq = 1'b0;
    tick();

    // Ack arriving on the last watchdog cycle wins over the error.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h480, 32'h0, 4'h0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("late ack mem_req", 32'(memReq), 32'h1);
    memAck = 1'b1;
    memRdata = 32'hCAFE_0001;
    tick();
    checkOutput("late ack dbus_ack", 32'(dbusAck), 32'h1);
    checkOutput("late ack dbus_err", 32'(dbusErr), 32'h0);
    checkOutput("late ack rdata", dbusRdata, 32'hCAFE_0001);
    memAck = 1'b0;
    dbusReq = 1'b0;
    tick();

    // Reset during GRANT_D, then a spurious ack while idle.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h600, 32'h1234_5678, 4'h3);
    tick();
    checkOutput("mid grant we", 32'(memWe), 32'h1);
    rst = 1'b1;
    tick();
    checkAllZero("mid reset");
    rst = 1'b0;
    dbusReq = 1'b0;
    tick();
    tick();
    memAck = 1'b1;
    memRdata = 32'hFFFF_FFFF;
    tick();
    checkOutput("spur ibus_ack", 32'(ibusAck), 32'h0);
    checkOutput("spur dbus_ack", 32'(dbusAck), 32'h0);
    checkOutput("spur mem_req", 32'(memReq), 32'h0);
    memAck = 1'b0;
    tick();
    checkOutput("spur acks later", 32'({ibusAck, dbusAck}), 32'h0);

    // A fresh fetch completes normally after the reset.
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("final addr", memAddr, 32'h700);
    memAck = 1'b1;
    memRdata = 32'h0000_0093;
    tick();
    checkOutput("final ibus_ack", 32'(ibusAck), 32'h1);
    checkOutput("final ibus_rdata", ibusRdata, 32'h93);
    memAck = 1'b0;
    ibusReq = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
